ahb_apb_slave_if: RTL and testbench

- Parametrised AHB-side front end of the AHB-to-APB bridge.
- Qualifies AHB transfers and decodes a configurable number of APB peripheral regions into a one-hot select.
- Pipelines address, write data and direction to a configurable depth.
- Generates HREADYout wait states, handshaking with the bridge APB FSM, and a two-cycle AHB ERROR response for unmapped accesses.

---
 rtl/ahb_apb_slave_if_if.sv | 38 +++
 rtl/ahb_apb_slave_if.sv | 176 +++++++++++++++++
 tb/tb_ahb_apb_slave_if.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/ahb_apb_slave_if_if.sv
// Bus bundle between the AHB master side and the bridge front end.
// The master modport drives the AHB/APB inputs; the slave modport is the front end.
interface ahb_apb_slave_if_if #(
    parameter int DATA_W     = 32,
    parameter int NUM_SEL    = 3,
    parameter int PIPE_DEPTH = 3
) ();
    logic [31:0]                  HADDR;
    logic [DATA_W-1:0]            HWDATA;
    logic [1:0]                   HTRANS;
    logic [2:0]                   HSIZE;
    logic                         HWRITE;
    logic                         HREADYin;
    logic [DATA_W-1:0]            PRDATA;
    logic                         xfer_done;
    logic                         HREADYout;
    logic [1:0]                   HRESP;
    logic [DATA_W-1:0]            HRDATA;
    logic                         valid;
    logic [NUM_SEL-1:0]           TEMP_SEL;
    logic                         HWRITEreg;
    logic [32*PIPE_DEPTH-1:0]     haddr_pipe;
    logic [DATA_W*PIPE_DEPTH-1:0] hwdata_pipe;

    modport master (
        output HADDR, HWDATA, HTRANS, HSIZE, HWRITE, HREADYin,
        output PRDATA, xfer_done,
        input  HREADYout, HRESP, HRDATA, valid, TEMP_SEL,
        input  HWRITEreg, haddr_pipe, hwdata_pipe
    );

    modport slave (
        input  HADDR, HWDATA, HTRANS, HSIZE, HWRITE, HREADYin,
        input  PRDATA, xfer_done,
        output HREADYout, HRESP, HRDATA, valid, TEMP_SEL,
        output HWRITEreg, haddr_pipe, hwdata_pipe
    );
endinterface

// File: rtl/ahb_apb_slave_if.sv
// AHB-side front end of the AHB-to-APB bridge: decode, pipelines, wait/error FSM.
// Optional alignment/size checking is enabled with `define AHB_SLV_ALIGN_CHECK_EN.
module ahb_apb_slave_if #(
    parameter int          DATA_W      = 32,
    parameter int          NUM_SEL     = 3,
    parameter logic [31:0] BASE_ADDR   = 32'h4000_0000,
    parameter int          WINDOW_BITS = 16,
    parameter int          REGION_BITS = 12,
    parameter int          PIPE_DEPTH  = 3
) (
    input logic               HCLK,
    input logic               HRESET,
    ahb_apb_slave_if_if.slave bus
);

    localparam int IDX_W = WINDOW_BITS - REGION_BITS;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ERR1 = 2'd2,
        S_ERR2 = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [NUM_SEL-1:0] sel_q, sel_d;
    logic               wr_q, wr_d;
    logic [31:0]        addr_q [PIPE_DEPTH];
    logic [DATA_W-1:0]  data_q [PIPE_DEPTH];

    logic               active;
    logic               in_win;
    logic [IDX_W-1:0]   idx;
    logic               idx_ok;
    logic               size_err;
    logic               mapped;
    logic               err_req;
    logic               accept_ok;
    logic               valid;

    assign active = bus.HTRANS[1] & bus.HREADYin;
    assign in_win = bus.HADDR[31:WINDOW_BITS] == BASE_ADDR[31:WINDOW_BITS];
    assign idx    = bus.HADDR[WINDOW_BITS-1:REGION_BITS];
    assign idx_ok = 32'(idx) < 32'(NUM_SEL);

`ifdef AHB_SLV_ALIGN_CHECK_EN
    assign size_err = ((bus.HSIZE == 3'b001) & bus.HADDR[0])
                    | ((bus.HSIZE == 3'b010) & (|bus.HADDR[1:0]))
                    | (bus.HSIZE > 3'b010);
`else
    logic unused_hsize;
    assign unused_hsize = ^bus.HSIZE;
    assign size_err     = 1'b0;
`endif

    assign mapped    = in_win & idx_ok & ~size_err;
    assign err_req   = active & in_win & ~mapped;
    assign accept_ok = (state_q == S_IDLE)
                     | ((state_q == S_WAIT) & bus.xfer_done);
    assign valid     = active & mapped & accept_ok & ~HRESET;

    // State register
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (valid) begin
                    state_d = S_WAIT;
                end else if (err_req) begin
                    state_d = S_ERR1;
                end
            end
            S_WAIT: begin
                if (bus.xfer_done) begin
                    if (valid) begin
                        state_d = S_WAIT;
                    end else if (err_req) begin
                        state_d = S_ERR1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_ERR1:  state_d = S_ERR2;
            S_ERR2:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        bus.HREADYout = 1'b1;
        bus.HRESP     = 2'b00;
        unique case (state_q)
            S_IDLE: begin
                bus.HREADYout = 1'b1;
                bus.HRESP     = 2'b00;
            end
            S_WAIT: begin
                bus.HREADYout = bus.xfer_done;
                bus.HRESP     = 2'b00;
            end
            S_ERR1: begin
                bus.HREADYout = 1'b0;
                bus.HRESP     = 2'b01;
            end
            S_ERR2: begin
                bus.HREADYout = 1'b1;
                bus.HRESP     = 2'b01;
            end
            default: begin
                bus.HREADYout = 1'b1;
                bus.HRESP     = 2'b00;
            end
        endcase
    end

    // Select and direction capture the accepted transfer only
    always_comb begin
        sel_d = sel_q;
        wr_d  = wr_q;
        if (valid) begin
            for (int i = 0; i < NUM_SEL; i++) begin
                sel_d[i] = (32'(idx) == 32'(i));
            end
            wr_d = bus.HWRITE;
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            sel_q <= '0;
            wr_q  <= 1'b0;
        end else begin
            sel_q <= sel_d;
            wr_q  <= wr_d;
        end
    end

    // Pipes follow the bus and stall only on HREADYin
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            for (int k = 0; k < PIPE_DEPTH; k++) begin
                addr_q[k] <= '0;
                data_q[k] <= '0;
            end
        end else if (bus.HREADYin) begin
            addr_q[0] <= bus.HADDR;
            data_q[0] <= bus.HWDATA;
            for (int k = 1; k < PIPE_DEPTH; k++) begin
                addr_q[k] <= addr_q[k-1];
                data_q[k] <= data_q[k-1];
            end
        end
    end

    for (genvar k = 0; k < PIPE_DEPTH; k++) begin : g_flat
        assign bus.haddr_pipe[32*k +: 32]         = addr_q[k];
        assign bus.hwdata_pipe[DATA_W*k +: DATA_W] = data_q[k];
    end

    assign bus.valid     = valid;
    assign bus.TEMP_SEL  = sel_q;
    assign bus.HWRITEreg = wr_q;
    assign bus.HRDATA    = bus.PRDATA;

endmodule

// File: tb/tb_ahb_apb_slave_if.sv
// Directed bench for ahb_apb_slave_if: cycle table plus corner-case sequences.
// Alignment expectations follow `define AHB_SLV_ALIGN_CHECK_EN.
module tb_ahb_apb_slave_if;

    localparam int DW = 32;
    localparam int NS = 3;
    localparam int PD = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    ahb_apb_slave_if_if #(.DATA_W(DW), .NUM_SEL(NS), .PIPE_DEPTH(PD)) bus ();

    ahb_apb_slave_if #(
        .DATA_W(DW), .NUM_SEL(NS), .BASE_ADDR(32'h4000_0000),
        .WINDOW_BITS(16), .REGION_BITS(12), .PIPE_DEPTH(PD)
    ) dut (
        .HCLK(clk),
        .HRESET(rst),
        .bus(bus)
    );

    typedef struct {
        logic [1:0]  tr;
        logic [31:0] addr;
        logic        wr;
        logic        rdy;
        logic        done;
        logic        ev;
        logic        erdy;
        logic [1:0]  eresp;
        logic [2:0]  esel;
        logic        ewr;
        logic [31:0] p0;
        logic [31:0] p1;
    } vec_t;

    vec_t tv [17];

    function automatic vec_t mk(
        input logic [1:0] tr, input logic [31:0] addr,
        input logic wr, input logic rdy, input logic done,
        input logic ev, input logic erdy, input logic [1:0] eresp,
        input logic [2:0] esel, input logic ewr,
        input logic [31:0] p0, input logic [31:0] p1);
        vec_t v;
        v.tr = tr; v.addr = addr; v.wr = wr; v.rdy = rdy;
        v.done = done; v.ev = ev; v.erdy = erdy; v.eresp = eresp;
        v.esel = esel; v.ewr = ewr; v.p0 = p0; v.p1 = p1;
        return v;
    endfunction

    function automatic logic [31:0] swp(input logic [31:0] a);
        return {a[15:0], a[31:16]};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drv(input logic [1:0] tr, input logic [31:0] addr,
                       input logic wr, input logic [2:0] sz,
                       input logic rdy, input logic done);
        bus.HTRANS    = tr;
        bus.HADDR     = addr;
        bus.HWRITE    = wr;
        bus.HSIZE     = sz;
        bus.HREADYin  = rdy;
        bus.xfer_done = done;
        bus.HWDATA    = swp(addr);
        bus.PRDATA    = addr ^ 32'hA5A5_A5A5;
    endtask

    initial begin
        tv[0]  = mk(2'b10, 32'h4000_2004, 1, 1, 0, 1, 1, 0, 3'b000, 0, 32'h0, 32'h0);
        tv[1]  = mk(2'b00, 32'h0,         0, 1, 0, 0, 0, 0, 3'b100, 1, 32'h4000_2004, 32'h0);
        tv[2]  = mk(2'b00, 32'h0,         0, 1, 0, 0, 0, 0, 3'b100, 1, 32'h0, 32'h4000_2004);
        tv[3]  = mk(2'b00, 32'h0,         0, 1, 1, 0, 1, 0, 3'b100, 1, 32'h0, 32'h0);
        tv[4]  = mk(2'b10, 32'h4000_0000, 0, 1, 0, 1, 1, 0, 3'b100, 1, 32'h0, 32'h0);
        tv[5]  = mk(2'b10, 32'h4000_1000, 0, 1, 1, 1, 1, 0, 3'b001, 0, 32'h4000_0000, 32'h0);
        tv[6]  = mk(2'b00, 32'h0,         0, 1, 1, 0, 1, 0, 3'b010, 0, 32'h4000_1000, 32'h4000_0000);
        tv[7]  = mk(2'b10, 32'h4000_5000, 0, 1, 0, 0, 1, 0, 3'b010, 0, 32'h0, 32'h4000_1000);
        tv[8]  = mk(2'b00, 32'h0,         0, 1, 0, 0, 0, 1, 3'b010, 0, 32'h4000_5000, 32'h0);
        tv[9]  = mk(2'b10, 32'h4000_0000, 0, 1, 0, 0, 1, 1, 3'b010, 0, 32'h0, 32'h4000_5000);
        tv[10] = mk(2'b00, 32'h0,         0, 1, 1, 0, 1, 0, 3'b010, 0, 32'h4000_0000, 32'h0);
        tv[11] = mk(2'b01, 32'h4000_0000, 0, 1, 0, 0, 1, 0, 3'b010, 0, 32'h0, 32'h4000_0000);
        tv[12] = mk(2'b10, 32'h5000_0000, 0, 1, 0, 0, 1, 0, 3'b010, 0, 32'h4000_0000, 32'h0);
        tv[13] = mk(2'b00, 32'h1234_5678, 0, 0, 0, 0, 1, 0, 3'b010, 0, 32'h5000_0000, 32'h4000_0000);
        tv[14] = mk(2'b00, 32'h0,         0, 0, 0, 0, 1, 0, 3'b010, 0, 32'h5000_0000, 32'h4000_0000);
        tv[15] = mk(2'b00, 32'h0,         0, 1, 0, 0, 1, 0, 3'b010, 0, 32'h5000_0000, 32'h4000_0000);
        tv[16] = mk(2'b00, 32'h0,         0, 1, 1, 0, 1, 0, 3'b010, 0, 32'h0, 32'h5000_0000);

        rst = 1'b1;
        drv(2'b10, 32'h4000_1000, 0, 3'b010, 1, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst valid", 64'(bus.valid), 64'd0);
        chk("rst hready", 64'(bus.HREADYout), 64'd1);
        chk("rst hresp", 64'(bus.HRESP), 64'd0);
        chk("rst sel", 64'(bus.TEMP_SEL), 64'd0);
        chk("rst wreg", 64'(bus.HWRITEreg), 64'd0);
        chk("rst apipe", 64'(|bus.haddr_pipe), 64'd0);
        chk("rst dpipe", 64'(|bus.hwdata_pipe), 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 17; i++) begin
            if (i != 0) @(negedge clk);
            drv(tv[i].tr, tv[i].addr, tv[i].wr, 3'b010, tv[i].rdy, tv[i].done);
            #1;
            chk($sformatf("v%0d valid", i), 64'(bus.valid), 64'(tv[i].ev));
            chk($sformatf("v%0d hready", i), 64'(bus.HREADYout), 64'(tv[i].erdy));
            chk($sformatf("v%0d hresp", i), 64'(bus.HRESP), 64'(tv[i].eresp));
            chk($sformatf("v%0d sel", i), 64'(bus.TEMP_SEL), 64'(tv[i].esel));
            chk($sformatf("v%0d wreg", i), 64'(bus.HWRITEreg), 64'(tv[i].ewr));
            chk($sformatf("v%0d ap0", i), 64'(bus.haddr_pipe[31:0]), 64'(tv[i].p0));
            chk($sformatf("v%0d ap1", i), 64'(bus.haddr_pipe[63:32]), 64'(tv[i].p1));
            chk($sformatf("v%0d dp0", i), 64'(bus.hwdata_pipe[31:0]), 64'(swp(tv[i].p0)));
            chk($sformatf("v%0d dp1", i), 64'(bus.hwdata_pipe[63:32]), 64'(swp(tv[i].p1)));
            chk($sformatf("v%0d hrdata", i), 64'(bus.HRDATA),
                64'(tv[i].addr ^ 32'hA5A5_A5A5));
        end
        chk("ap2 end", 64'(bus.haddr_pipe[95:64]), 64'h4000_0000);
        chk("dp2 end", 64'(bus.hwdata_pipe[95:64]), 64'(swp(32'h4000_0000)));

        // WAIT completing straight into an unmapped access
        @(negedge clk);
        drv(2'b10, 32'h4000_2000, 0, 3'b010, 1, 0); #1;
        chk("wa valid", 64'(bus.valid), 64'd1);
        @(negedge clk);
        drv(2'b10, 32'h4000_7000, 0, 3'b010, 1, 1); #1;
        chk("wb valid", 64'(bus.valid), 64'd0);
        chk("wb hready", 64'(bus.HREADYout), 64'd1);
        @(negedge clk);
        drv(2'b00, 32'h0, 0, 3'b010, 1, 0); #1;
        chk("we1 hready", 64'(bus.HREADYout), 64'd0);
        chk("we1 hresp", 64'(bus.HRESP), 64'd1);
        @(negedge clk); #1;
        chk("we2 hready", 64'(bus.HREADYout), 64'd1);
        chk("we2 hresp", 64'(bus.HRESP), 64'd1);
        @(negedge clk); #1;
        chk("wi hresp", 64'(bus.HRESP), 64'd0);
        chk("wi sel", 64'(bus.TEMP_SEL), 64'd4);

        // Misaligned word access
        @(negedge clk);
        drv(2'b10, 32'h4000_0002, 0, 3'b010, 1, 0); #1;
`ifdef AHB_SLV_ALIGN_CHECK_EN
        chk("al valid", 64'(bus.valid), 64'd0);
        @(negedge clk);
        drv(2'b00, 32'h0, 0, 3'b010, 1, 0); #1;
        chk("al e1 hready", 64'(bus.HREADYout), 64'd0);
        chk("al e1 hresp", 64'(bus.HRESP), 64'd1);
        @(negedge clk); #1;
        chk("al e2 hready", 64'(bus.HREADYout), 64'd1);
        chk("al e2 hresp", 64'(bus.HRESP), 64'd1);
        @(negedge clk); #1;
        chk("al sel", 64'(bus.TEMP_SEL), 64'd4);
`else
        chk("al valid", 64'(bus.valid), 64'd1);
        @(negedge clk);
        drv(2'b00, 32'h0, 0, 3'b010, 1, 0); #1;
        chk("al sel", 64'(bus.TEMP_SEL), 64'd1);
        chk("al hready", 64'(bus.HREADYout), 64'd0);
        chk("al hresp", 64'(bus.HRESP), 64'd0);
        @(negedge clk);
        drv(2'b00, 32'h0, 0, 3'b010, 1, 1); #1;
        chk("al done", 64'(bus.HREADYout), 64'd1);
        @(negedge clk);
        drv(2'b00, 32'h0, 0, 3'b010, 1, 0); #1;
`endif

        // Reset in the middle of a transfer
        @(negedge clk);
        drv(2'b10, 32'h4000_1000, 1, 3'b010, 1, 0); #1;
        chk("rm valid", 64'(bus.valid), 64'd1);
        @(negedge clk);
        rst = 1'b1;
        drv(2'b10, 32'h4000_0000, 0, 3'b010, 1, 1); #1;
        chk("rm valid rst", 64'(bus.valid), 64'd0);
        chk("rm sel", 64'(bus.TEMP_SEL), 64'd2);
        @(negedge clk);
        rst = 1'b0;
        drv(2'b00, 32'h0, 0, 3'b010, 1, 0); #1;
        chk("rm hready", 64'(bus.HREADYout), 64'd1);
        chk("rm hresp", 64'(bus.HRESP), 64'd0);
        chk("rm sel0", 64'(bus.TEMP_SEL), 64'd0);
        chk("rm wreg", 64'(bus.HWRITEreg), 64'd0);
        chk("rm apipe", 64'(|bus.haddr_pipe), 64'd0);
        @(negedge clk);
        drv(2'b11, 32'h4000_0000, 0, 3'b010, 1, 0); #1;
        chk("rm idle valid", 64'(bus.valid), 64'd1);
        @(negedge clk);
        drv(2'b00, 32'h0, 0, 3'b010, 1, 0); #1;
        chk("rm sel1", 64'(bus.TEMP_SEL), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
